pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Parametrised PLL control and reset sequencer; next generation of the fixed single-output PLL wrapper.
- Drives the PLL reset and qualifies its `locked` output with a synchroniser and stability filter.
- Retries on lock timeout, up to a limit; flags permanent failure.
- Releases NUM_DOMAINS downstream active-low resets in a staggered order.
- Counts lock-loss events.
- Sits between the PLL wrapper and every consumer of its output clocks; runs on the PLL reference clock.

Parameters:
- RST_HOLD_CYCLES, 16: cycles pll_rst is held high per attempt (>=1).
- LOCK_FILTER_CYCLES, 64: consecutive synchronised-locked cycles required to accept lock (>=1).
- LOCK_TIMEOUT_CYCLES, 4096: cycles allowed from PLL reset release to accepted lock.
- MAX_RETRIES, 3: lock attempts before FAIL (>=1).
- NUM_DOMAINS, 2: number of downstream reset outputs (>=1).
- STAGGER_CYCLES, 8: spacing between successive domain reset releases (>=1).
- CNT_W, 8: width of the status counters.

Ports:
- refclk, input, 1: reference clock; all logic runs here.
- rst_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: raw PLL locked; asynchronous to refclk.
- relock_req, input, 1: single-cycle pulse that forces a new lock sequence.
- pll_rst, output, 1: active-high PLL reset.
- domain_rst_n, output, NUM_DOMAINS: per-domain active-low resets.
- ready, output, 1: all domains released and lock stable.
- fail, output, 1: retries exhausted.
- lock_loss_count, output, CNT_W: saturating count of lock losses seen in RUN.
- retry_count, output, CNT_W: timeouts in the current sequence.

Behaviour:
- Reset values (rst_n low, applied asynchronously):
  - pll_rst = 1, domain_rst_n = all 0, ready = 0, fail = 0.
  - Both counters = 0; state = HOLD; all timers = 0.
- Synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s. A change on pll_locked is visible on locked_s 2 cycles later. Every decision uses locked_s only.
- All outputs are registered.
- HOLD:
  - pll_rst = 1, all domain_rst_n = 0, ready = 0.
  - Occupies exactly RST_HOLD_CYCLES cycles, then moves to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst = 0. The timeout timer starts at 0 on entry.
  - locked_s = 1 -> FILTER, with filter count = 1.
- FILTER:
  - Filter count increments while locked_s = 1.
  - Reaching LOCK_FILTER_CYCLES -> RELEASE.
  - locked_s = 0 -> back to WAIT_LOCK. The filter count clears; the timeout timer is not reset.
- Timeout (applies in WAIT_LOCK and FILTER): when the timeout timer reaches LOCK_TIMEOUT_CYCLES, retry_count increments.
  - If the new value equals MAX_RETRIES -> FAIL.
  - Otherwise -> HOLD.
  - A timeout takes priority over the filter completing in the same cycle.
- RELEASE:
  - Domain i deasserts its reset (domain_rst_n[i] = 1) exactly STAGGER_CYCLES*(i+1) cycles after RELEASE is entered.
  - ready rises in the same cycle as the last domain's release; the state then moves to RUN.
  - locked_s = 0 during RELEASE behaves as a lock loss (see RUN).
- RUN:
  - ready = 1.
  - locked_s = 0 -> lock_loss_count increments, saturating at 2^CNT_W-1. Next cycle: all domain_rst_n = 0, ready = 0, state = HOLD, retry_count = 0.
- FAIL:
  - pll_rst = 1, fail = 1, domain resets asserted, ready = 0.
  - Exited only by relock_req or rst_n.
- relock_req:
  - Honoured in RELEASE, RUN and FAIL: next cycle state = HOLD, fail = 0, retry_count = 0. lock_loss_count is not incremented.
  - Ignored in HOLD, WAIT_LOCK and FILTER.
- Simultaneous relock_req and a lock drop in RUN: the lock drop is counted and the state goes to HOLD once.
- rst_n asserted mid-sequence: all state returns to reset values immediately, including lock_loss_count.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum (HOLD, WAIT_LOCK, FILTER, RELEASE, RUN, FAIL);
  - a clog2-based timer-width helper;
  - the default parameter constants.
- One sub-module, sync_2ff: parametrised-width 2-flop synchroniser with asynchronous active-low reset. It is reused later for other asynchronous status bits.

Test Plan (all parameters at defaults):
- Clean lock: rst_n deasserted, pll_locked high from cycle 30 ->
  - pll_rst falls after 16 cycles;
  - locked_s rises 2 cycles after pll_locked;
  - domain_rst_n[0] rises 64+8 cycles after locked_s, domain_rst_n[1] 8 cycles later, ready rises in that same cycle;
  - retry_count = 0.
- Glitchy lock: locked high 40 cycles, low 1 cycle, then high -> filter restarts; release occurs 64 cycles after the second rise.
- No lock: pll_locked held 0 ->
  - 3 timeouts of 4096 cycles, separated by 16-cycle HOLDs;
  - retry_count = 3, fail = 1, pll_rst = 1;
  - relock_req then clears fail, and HOLD is re-entered.
- Lock loss in RUN: drop pll_locked ->
  - lock_loss_count 0 -> 1;
  - all domain_rst_n low and ready low 3 cycles after the drop;
  - full sequence reruns;
  - repeat 256 losses -> count saturates at 255.
- Mid-operation reset: assert rst_n during RELEASE, after domain 0 is released -> all outputs return to reset values asynchronously.
- Simultaneous events: relock_req in the same cycle as locked_s falls in RUN -> one increment and a single HOLD entry.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock/reset sequencer.
//   seq_state_e : sequencer FSM states
//   tmr_w()     : width needed to hold a counter value up to max_val
//   DEF_*       : default parameter values used by the top
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN,
        FAIL
    } seq_state_e;

    function automatic int tmr_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_RST_HOLD_CYCLES     = 16;
    localparam int DEF_LOCK_FILTER_CYCLES  = 64;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 4096;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_NUM_DOMAINS         = 2;
    localparam int DEF_STAGGER_CYCLES      = 8;
    localparam int DEF_CNT_W               = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level signals.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (clears both stages)
//   d     : asynchronous input bits
//   q     : synchronised output, 2 clk edges after d
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL control and downstream reset sequencer, clocked by the PLL reference.
//   refclk          : reference clock
//   rst_n           : asynchronous active-low reset
//   pll_locked      : raw PLL lock indicator (asynchronous)
//   relock_req      : pulse forcing a new lock sequence (RELEASE/RUN/FAIL)
//   pll_rst         : active-high PLL reset
//   domain_rst_n    : per-domain active-low resets, released in stagger order
//   ready           : all domains out of reset and lock stable
//   fail            : lock attempts exhausted
//   lock_loss_count : saturating count of lock losses after release started
//   retry_count     : lock timeouts in the current sequence
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fail,
    output logic [CNT_W-1:0]       lock_loss_count,
    output logic [CNT_W-1:0]       retry_count
);

    localparam int REL_CYCLES = STAGGER_CYCLES * NUM_DOMAINS;
    // One phase timer serves both HOLD and RELEASE; size it for the longer.
    localparam int TMR_W = tmr_w((RST_HOLD_CYCLES > REL_CYCLES) ? RST_HOLD_CYCLES : REL_CYCLES);
    localparam int TMO_W = tmr_w(LOCK_TIMEOUT_CYCLES);
    localparam int FLT_W = tmr_w(LOCK_FILTER_CYCLES);

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REL_LAST  = TMR_W'(REL_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRIES);

    seq_state_e             state, state_nxt;
    logic [TMR_W-1:0]       tmr, tmr_nxt;
    logic [TMO_W-1:0]       tmo, tmo_nxt;
    logic [FLT_W-1:0]       filt, filt_nxt;
    logic [CNT_W-1:0]       retry_nxt, loss_nxt;
    logic [NUM_DOMAINS-1:0] dom_nxt;
    logic                   ready_nxt;
    logic                   restart;
    logic                   locked_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        tmo_nxt   = tmo;
        filt_nxt  = filt;
        retry_nxt = retry_count;
        loss_nxt  = lock_loss_count;
        dom_nxt   = domain_rst_n;
        ready_nxt = ready;
        restart   = 1'b0;

        unique case (state)
            HOLD: begin
                if (tmr == HOLD_LAST) begin
                    state_nxt = WAIT_LOCK;
                    tmr_nxt   = '0;
                    tmo_nxt   = '0;
                    filt_nxt  = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            WAIT_LOCK, FILTER: begin
                // Timeout is checked first so it wins over a filter completing
                // in the same cycle. The timer keeps running across filter
                // restarts: it bounds the whole attempt, not one lock window.
                if (tmo == TMO_LAST) begin
                    retry_nxt = retry_count + 1'b1;
                    state_nxt = (retry_nxt == RETRY_MAX) ? FAIL : HOLD;
                    tmr_nxt   = '0;
                    filt_nxt  = '0;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                        filt_nxt  = '0;
                    end else if (state == WAIT_LOCK && LOCK_FILTER_CYCLES > 1) begin
                        state_nxt = FILTER;
                        filt_nxt  = FLT_W'(1);
                    end else if (state == WAIT_LOCK || filt == FLT_LAST) begin
                        state_nxt = RELEASE;
                        filt_nxt  = '0;
                        tmr_nxt   = '0;
                    end else begin
                        filt_nxt = filt + 1'b1;
                    end
                end
            end
            RELEASE, RUN: begin
                if (!locked_s || relock_req) begin
                    // A coincident relock and lock drop is one restart, but
                    // the drop is still counted.
                    restart = 1'b1;
                    if (!locked_s && lock_loss_count != '1)
                        loss_nxt = lock_loss_count + 1'b1;
                end else if (state == RELEASE) begin
                    tmr_nxt = tmr + 1'b1;
                    for (int i = 0; i < NUM_DOMAINS; i++)
                        if (tmr == TMR_W'(STAGGER_CYCLES * (i + 1) - 1))
                            dom_nxt[i] = 1'b1;
                    if (tmr == REL_LAST) begin
                        ready_nxt = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            FAIL: begin
                if (relock_req)
                    restart = 1'b1;
            end
            default: state_nxt = HOLD;
        endcase

        if (restart) begin
            state_nxt = HOLD;
            tmr_nxt   = '0;
            retry_nxt = '0;
        end

        // Downstream domains only see reset released while lock is held.
        if (state_nxt != RELEASE && state_nxt != RUN) begin
            dom_nxt   = '0;
            ready_nxt = 1'b0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= HOLD;
            tmr             <= '0;
            tmo             <= '0;
            filt            <= '0;
            pll_rst         <= 1'b1;
            domain_rst_n    <= '0;
            ready           <= 1'b0;
            fail            <= 1'b0;
            lock_loss_count <= '0;
            retry_count     <= '0;
        end else begin
            state           <= state_nxt;
            tmr             <= tmr_nxt;
            tmo             <= tmo_nxt;
            filt            <= filt_nxt;
            pll_rst         <= (state_nxt == HOLD) || (state_nxt == FAIL);
            domain_rst_n    <= dom_nxt;
            ready           <= ready_nxt;
            fail            <= (state_nxt == FAIL);
            lock_loss_count <= loss_nxt;
            retry_count     <= retry_nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer at default parameters.
// All driving and sampling happens 1ns after a rising refclk edge.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic [1:0] domain_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] lock_loss_count;
    logic [7:0] retry_count;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_sequencer u_dut (
        .refclk          (refclk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .relock_req      (relock_req),
        .pll_rst         (pll_rst),
        .domain_rst_n    (domain_rst_n),
        .ready           (ready),
        .fail            (fail),
        .lock_loss_count (lock_loss_count),
        .retry_count     (retry_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, pll_rst, 1);
        chk({tag, "_dom"}, domain_rst_n, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_loss"}, lock_loss_count, 0);
        chk({tag, "_retry"}, retry_count, 0);
    endtask

    task automatic wait_ready(input int lim);
        int n = 0;
        while (!ready && n < lim) begin
            tick(1);
            n++;
        end
        chk("ready_seen", ready, 1);
    endtask

    // Drop lock until the sequencer reacts (3 edges), then restore it.
    task automatic lose_lock();
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        tick(3);
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;

        // Clean lock: pll_rst held 16 edges, lock arrives at edge 30.
        tick(15); chk("hold_pll_rst_15", pll_rst, 1);
        tick(1);  chk("hold_pll_rst_16", pll_rst, 0);
        tick(14);
        pll_locked = 1'b1;
        tick(1);  chk("sync_1", u_dut.locked_s, 0);
        tick(1);  chk("sync_2", u_dut.locked_s, 1);
        tick(71); chk("clean_dom_71", domain_rst_n, 2'b00);
        tick(1);  chk("clean_dom_72", domain_rst_n, 2'b01);
        tick(7);  chk("clean_dom_79", domain_rst_n, 2'b01);
                  chk("clean_ready_79", ready, 0);
        tick(1);  chk("clean_dom_80", domain_rst_n, 2'b11);
                  chk("clean_ready_80", ready, 1);
                  chk("clean_retry", retry_count, 0);
                  chk("clean_pll_rst", pll_rst, 0);

        // Relock from RUN with lock dropping, then a one-cycle lock glitch.
        tick(2);
        pll_locked = 1'b0;
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        chk("relock_ready", ready, 0);
        chk("relock_dom", domain_rst_n, 2'b00);
        chk("relock_loss", lock_loss_count, 0);
        chk("relock_pll_rst", pll_rst, 1);
        tick(16); chk("relock_hold_end", pll_rst, 0);
        tick(3);  pll_locked = 1'b1;   // locked_s rises 2 edges later
        tick(40); pll_locked = 1'b0;
        tick(1);  pll_locked = 1'b1;   // second locked_s rise at next+1 edge
        tick(73); chk("glitch_dom_early", domain_rst_n, 2'b00);
        tick(1);  chk("glitch_dom0", domain_rst_n, 2'b01);
        tick(8);  chk("glitch_ready", ready, 1);

        // Single lock loss in RUN.
        tick(2);
        pll_locked = 1'b0;
        tick(2);  chk("loss_ready_pre", ready, 1);
                  chk("loss_dom_pre", domain_rst_n, 2'b11);
        tick(1);  chk("loss_ready", ready, 0);
                  chk("loss_dom", domain_rst_n, 2'b00);
                  chk("loss_cnt1", lock_loss_count, 1);
                  chk("loss_pll_rst", pll_rst, 1);
        pll_locked = 1'b1;
        wait_ready(200);
        chk("rerun_retry", retry_count, 0);

        // relock_req coincident with the lock drop being seen.
        tick(2);
        pll_locked = 1'b0;
        tick(2);  relock_req = 1'b1;
        tick(1);  relock_req = 1'b0;
                  chk("simul_cnt2", lock_loss_count, 2);
                  chk("simul_ready", ready, 0);
        pll_locked = 1'b1;
        tick(15); chk("simul_hold_15", pll_rst, 1);
        tick(1);  chk("simul_hold_16", pll_rst, 0);
        wait_ready(200);

        // Saturation: 253 more losses reach 255, one more must stick.
        for (int i = 0; i < 253; i++) begin
            lose_lock();
            wait_ready(200);
        end
        chk("sat_255", lock_loss_count, 255);
        lose_lock();
        wait_ready(200);
        chk("sat_hold", lock_loss_count, 255);

        // No lock: three 4096-cycle timeouts separated by 16-cycle HOLDs.
        pll_locked = 1'b0;
        tick(3);  chk("nolock_hold", pll_rst, 1);
        tick(4111); chk("to1_pre", retry_count, 0);
        tick(1);  chk("to1_retry", retry_count, 1);
                  chk("to1_pll_rst", pll_rst, 1);
        tick(15); chk("to1_hold_15", pll_rst, 1);
        tick(1);  chk("to1_hold_16", pll_rst, 0);
        tick(8207); chk("to3_pre_retry", retry_count, 2);
                  chk("to3_pre_fail", fail, 0);
        tick(1);  chk("to3_retry", retry_count, 3);
                  chk("to3_fail", fail, 1);
                  chk("to3_pll_rst", pll_rst, 1);
        tick(4);  chk("fail_sticky", fail, 1);
        relock_req = 1'b1;
        tick(1);  relock_req = 1'b0;
                  chk("relock_fail", fail, 0);
                  chk("relock_retry", retry_count, 0);
                  chk("relock_hold", pll_rst, 1);
        tick(15); chk("relock_hold_15", pll_rst, 1);
        tick(1);  chk("relock_hold_16", pll_rst, 0);

        // Reset mid-RELEASE, after domain 0 is out of reset.
        pll_locked = 1'b1;
        begin
            int n = 0;
            while (domain_rst_n[0] !== 1'b1 && n < 200) begin
                tick(1);
                n++;
            end
        end
        tick(2);
        chk("mid_dom_pre", domain_rst_n, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        tick(2);
        rst_n = 1'b1;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
